l2_req_arbiter: RTL and testbench
=================================

Name: l2_req_arbiter

Overview:
Round-robin arbiter that shares the single L1-side port of the L2 cache between NUM_REQ L1 requesters (one per core).
- Accepts level-held read/write requests from each L1.
- Issues one single-cycle rd/wr pulse to the L2 and waits for the L2 ready response.
- Returns the line data and a one-cycle done pulse to the granted requester.
- Only one L2 transaction is outstanding at a time; the arbiter sits between the L1 caches and the L2 cache.

Parameters:
NUM_REQ, 2, number of L1 requesters (2..8)
ADDR_W, 32, address width
LINE_W, `L2_LINE_WIDTH (512), cache line width in bits
TIMEOUT_CYCLES, 1024, watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  asynchronous active-low reset
req_rd  in  NUM_REQ  per-requester read request, level, held until matching req_done
req_wr  in  NUM_REQ  per-requester write request, level, held until matching req_done
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*LINE_W  packed write lines; requester i at [i*LINE_W +: LINE_W]
req_rdata  out  LINE_W  returned line, valid in the req_done cycle
req_done  out  NUM_REQ  one-hot, one-cycle completion pulse
grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester
busy  out  1  high from grant until req_done inclusive
l2_addr  out  ADDR_W  address to L2
l2_wdata  out  LINE_W  write line to L2
l2_rd  out  1  one-cycle read pulse to L2
l2_wr  out  1  one-cycle write pulse to L2
l2_rdata  in  LINE_W  line from L2
l2_ready  in  1  L2 completion indication
timeout_err  out  1  one-cycle watchdog pulse (0 when ARB_TIMEOUT_EN is undefined)

Behaviour:
- Reset values (async, immediate): all outputs 0, state IDLE, round-robin pointer 0, watchdog counter 0.
- A reset mid-transaction abandons the transaction; no req_done is issued.
- States:
  - IDLE: arbitration is combinational over active = req_rd|req_wr, searching from pointer upward with wrap. If any bit is active, on the clock edge: register grant_id, latch addr/wdata/op from the winner, drive l2_addr/l2_wdata, go to ISSUE. If no bit is active, stay in IDLE.
  - ISSUE: exactly one cycle with l2_rd or l2_wr = 1, never both. If the winner had both rd and wr set, it is treated as a write. Then go to WAIT.
  - WAIT: l2_rd/l2_wr = 0; l2_addr/l2_wdata are held stable. When l2_ready = 1, capture l2_rdata into req_rdata and go to DONE.
  - DONE: req_done[grant_id] = 1 for one cycle; pointer <= grant_id+1 mod NUM_REQ; go to IDLE.
- l2_ready is ignored in IDLE, ISSUE and DONE.
- Minimum turnaround: a request asserted in cycle T gets l2_rd/l2_wr in T+1, and req_done one cycle after l2_ready is seen in WAIT.
- The requester must drop its request in the cycle after req_done. If it is still high, it re-arbitrates as a new request, at lowest priority in the rotation.
- A requester deasserting mid-transaction does not abort it; req_done still pulses.
- On a write, req_rdata holds whatever l2_rdata was at capture; the requester ignores it.
- Fairness: with all NUM_REQ requesters continuously active, grants rotate 0,1,...,NUM_REQ-1,0,...
- busy = (state != IDLE).

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with no l2_ready, timeout_err pulses for one cycle and the FSM goes to IDLE.
  - No req_done is issued and the pointer advances past grant_id.
- Undefined: no counter logic; timeout_err is tied to 0 and WAIT waits indefinitely.

Test Plan:
1. Single read: req_rd[0]=1, addr 0x0000_1000. L2 asserts l2_ready 10 cycles after the l2_rd pulse with rdata={8{64'hDEADBEEFCAFEBABE}} -> exactly one l2_rd pulse with l2_addr=0x1000, then req_done=2'b01 one cycle after ready, req_rdata matches.
2. Simultaneous: req_rd[0] and req_wr[1] both asserted from reset, requests held after done -> grants in order 0,1,0,1. Requester 1 shows l2_wr pulse with l2_wdata={8{64'hCAFEBABECAFEBABE}}; l2_rd and l2_wr are never high together.
3. Stability: during WAIT, change req_addr[0] to 0x9000 -> l2_addr stays 0x1000 until DONE; l2_ready pulsed during ISSUE has no effect.
4. Reset mid-WAIT: drop rst_n for 1 cycle -> outputs 0 immediately, no req_done, next grant goes to requester 0.
5. Both rd and wr on requester 1 -> single l2_wr pulse only.
6. With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, l2_ready never asserted -> timeout_err pulses 16 cycles after WAIT entry, no req_done, busy drops, next grant goes to requester 1 when both are requesting.

Source files
------------

// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter: round-robin arbiter sharing the L2 cache port among NUM_REQ L1s.
// Only one L2 transaction is outstanding at a time. Each grant goes through
// IDLE -> ISSUE -> WAIT -> DONE.
// Optional feature: define ARB_TIMEOUT_EN to add a WAIT watchdog that aborts
// the transaction after TIMEOUT_CYCLES cycles without l2_ready.
`ifndef L2_LINE_WIDTH
`define L2_LINE_WIDTH 512
`endif

module l2_req_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned LINE_W         = `L2_LINE_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_rd,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*LINE_W-1:0]     req_wdata,
  output logic [LINE_W-1:0]             req_rdata,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic [ADDR_W-1:0]             l2_addr,
  output logic [LINE_W-1:0]             l2_wdata,
  output logic                          l2_rd,
  output logic                          l2_wr,
  input  logic [LINE_W-1:0]             l2_rdata,
  input  logic                          l2_ready,
  output logic                          timeout_err
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t             state;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     ptr_next;
  logic [IDW-1:0]     win_id;
  logic               win_vld;
  logic [NUM_REQ-1:0] active;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  // Round-robin search: first active requester at or above ptr, wrapping around.
  always_comb begin
    int unsigned idx;
    active  = req_rd | req_wr;
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      if (!win_vld && active[idx]) begin
        win_vld = 1'b1;
        win_id  = IDW'(idx);
      end
    end
  end

  // The requester after the current grant becomes highest priority next time.
  always_comb begin
    ptr_next = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  end

  // Transaction FSM; every output is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      l2_addr   <= '0;
      l2_wdata  <= '0;
      l2_rd     <= 1'b0;
      l2_wr     <= 1'b0;
      req_rdata <= '0;
      req_done  <= '0;
`ifdef ARB_TIMEOUT_EN
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          req_done <= '0;
          if (win_vld) begin
            grant_id <= win_id;
            l2_addr  <= req_addr[win_id*ADDR_W +: ADDR_W];
            l2_wdata <= req_wdata[win_id*LINE_W +: LINE_W];
            // Write takes precedence when both rd and wr are set.
            l2_wr    <= req_wr[win_id];
            l2_rd    <= ~req_wr[win_id];
            busy     <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          l2_rd <= 1'b0;
          l2_wr <= 1'b0;
`ifdef ARB_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (l2_ready) begin
            req_rdata <= l2_rdata;
            req_done  <= NUM_REQ'(1) << grant_id;
            state     <= S_DONE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            ptr         <= ptr_next;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          req_done <= '0;
          ptr      <= ptr_next;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Directed testbench for l2_req_arbiter (NUM_REQ=2). Define ARB_TIMEOUT_EN
// to also exercise the watchdog with TIMEOUT_CYCLES=16.
module tb_l2_req_arbiter;
  localparam int NR = 2;
  localparam int AW = 32;
  localparam int LW = 512;
`ifdef ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_rd, req_wr;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*LW-1:0]  req_wdata;
  logic [LW-1:0]     req_rdata;
  logic [NR-1:0]     req_done;
  logic              grant_id;
  logic              busy;
  logic [AW-1:0]     l2_addr;
  logic [LW-1:0]     l2_wdata;
  logic              l2_rd, l2_wr;
  logic [LW-1:0]     l2_rdata;
  logic              l2_ready;
  logic              timeout_err;

  l2_req_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_rd(req_rd), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rdata(req_rdata),
    .req_done(req_done), .grant_id(grant_id), .busy(busy),
    .l2_addr(l2_addr), .l2_wdata(l2_wdata), .l2_rd(l2_rd), .l2_wr(l2_wr),
    .l2_rdata(l2_rdata), .l2_ready(l2_ready), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rd_p = 0, wr_p = 0, both_p = 0, to_p = 0, done_p = 0;

  logic [LW-1:0] pat1, pat2;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_issue(input string tag);
    int n;
    n = 0;
    while (!(l2_rd | l2_wr) && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_issue_seen"}, LW'(l2_rd | l2_wr), LW'(1));
  endtask

  // Called at the ISSUE sample point; ends at the DONE sample point.
  task automatic serve(input int lat, input logic [LW-1:0] data);
    repeat (lat) tick();
    l2_ready = 1'b1;
    l2_rdata = data;
    tick();
    l2_ready = 1'b0;
  endtask

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (l2_rd) rd_p++;
    if (l2_wr) wr_p++;
    if (l2_rd && l2_wr) both_p++;
    if (timeout_err) to_p++;
    if (|req_done) done_p++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    int snap_rd, snap_wr, snap_done, n;
    logic g;
    pat1 = {8{64'hDEADBEEFCAFEBABE}};
    pat2 = {8{64'hCAFEBABECAFEBABE}};
    rst_n = 1'b0; req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    l2_rdata = '0; l2_ready = 1'b0;
    tick(); tick();

    check("rst_done",  LW'(req_done), '0);
    check("rst_busy",  LW'(busy), '0);
    check("rst_grant", LW'(grant_id), '0);
    check("rst_l2rd",  LW'(l2_rd | l2_wr), '0);
    check("rst_addr",  LW'(l2_addr), '0);
    check("rst_rdata", req_rdata, '0);
    check("rst_to",    LW'(timeout_err), '0);

    // Simultaneous requests from reset, held after done: grants 0,1,0,1.
    req_rd = 2'b01; req_wr = 2'b10;
    req_addr = {32'h0000_2000, 32'h0000_1000};
    req_wdata = {pat2, 512'h0};
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_issue("t2");
      g = 1'(k % 2);
      check("t2_grant", LW'(grant_id), LW'(g));
      if (g == 1'b0) begin
        check("t2_rd", LW'({l2_rd, l2_wr}), LW'(2'b10));
        check("t2_addr0", LW'(l2_addr), LW'(32'h1000));
      end else begin
        check("t2_wr", LW'({l2_rd, l2_wr}), LW'(2'b01));
        check("t2_addr1", LW'(l2_addr), LW'(32'h2000));
        check("t2_wdata", l2_wdata, pat2);
      end
      serve(2, pat1);
      check("t2_done", LW'(req_done), LW'(2'b01 << g));
      tick();
    end
    req_rd = '0; req_wr = '0;
    check("t2_never_both", LW'(both_p), '0);
    tick();

    // Single read with a 10-cycle L2 latency.
    snap_rd = rd_p;
    req_rd = 2'b01; req_addr = {32'h0, 32'h0000_1000};
    tick();
    check("t1_rd", LW'(l2_rd), LW'(1));
    check("t1_addr", LW'(l2_addr), LW'(32'h1000));
    check("t1_busy", LW'(busy), LW'(1));
    check("t1_grant", LW'(grant_id), '0);
    serve(10, pat1);
    check("t1_done", LW'(req_done), LW'(2'b01));
    check("t1_rdata", req_rdata, pat1);
    req_rd = '0;
    check("t1_one_rd", LW'(rd_p - snap_rd), LW'(1));
    tick();
    check("t1_done_clr", LW'(req_done), '0);
    check("t1_idle", LW'(busy), '0);

    // Address stability during WAIT; l2_ready in ISSUE is ignored.
    req_rd = 2'b01; req_addr = {32'h0, 32'h0000_1000};
    tick();
    l2_ready = 1'b1; l2_rdata = pat2;
    tick();
    l2_ready = 1'b0;
    check("t3_ready_ignored", LW'(req_done), '0);
    check("t3_busy", LW'(busy), LW'(1));
    req_addr = {32'h0, 32'h0000_9000};
    repeat (3) tick();
    check("t3_hold", LW'(l2_addr), LW'(32'h1000));
    l2_ready = 1'b1; l2_rdata = pat1;
    tick();
    l2_ready = 1'b0;
    check("t3_done", LW'(req_done), LW'(2'b01));
    check("t3_hold_done", LW'(l2_addr), LW'(32'h1000));
    check("t3_rdata", req_rdata, pat1);
    req_rd = '0; req_addr = {32'h0, 32'h0000_1000};
    tick();

    // Reset mid-WAIT: pointer was 1, so requester 1 wins first, then 0 after reset.
    snap_done = done_p;
    req_rd = 2'b11;
    tick();
    check("t4_grant1", LW'(grant_id), LW'(1));
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("t4_rst_busy", LW'(busy), '0);
    check("t4_rst_grant", LW'(grant_id), '0);
    check("t4_rst_addr", LW'(l2_addr), '0);
    check("t4_rst_done", LW'(req_done), '0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t4_grant0", LW'(grant_id), '0);
    check("t4_rd", LW'(l2_rd), LW'(1));
    check("t4_no_done", LW'(done_p - snap_done), '0);
    serve(3, pat2);
    check("t4_done", LW'(req_done), LW'(2'b01));
    check("t4_rdata", req_rdata, pat2);
    req_rd = '0;
    tick();

    // Requester 1 with both rd and wr: single write pulse only.
    snap_rd = rd_p; snap_wr = wr_p;
    req_rd = 2'b10; req_wr = 2'b10;
    req_addr = {32'h0000_3000, 32'h0000_1000};
    req_wdata = {pat1, 512'h0};
    tick();
    check("t5_op", LW'({l2_rd, l2_wr}), LW'(2'b01));
    check("t5_wdata", l2_wdata, pat1);
    check("t5_addr", LW'(l2_addr), LW'(32'h3000));
    serve(4, '0);
    check("t5_done", LW'(req_done), LW'(2'b10));
    req_rd = '0; req_wr = '0;
    check("t5_rd_cnt", LW'(rd_p - snap_rd), '0);
    check("t5_wr_cnt", LW'(wr_p - snap_wr), LW'(1));
    tick();

`ifdef ARB_TIMEOUT_EN
    // Watchdog: no l2_ready, abort after 16 WAIT cycles, pointer moves to 1.
    req_rd = 2'b11;
    tick();
    check("t6_grant0", LW'(grant_id), '0);
    snap_done = done_p;
    tick();
    n = 0;
    while (!timeout_err && n < 100) begin
      tick();
      n++;
    end
    check("t6_latency", LW'(n), LW'(16));
    check("t6_busy", LW'(busy), '0);
    check("t6_no_done", LW'(done_p - snap_done), '0);
    tick();
    check("t6_grant1", LW'(grant_id), LW'(1));
    req_rd = '0;
    serve(1, pat1);
    check("t6_done", LW'(req_done), LW'(2'b10));
    tick();
    check("t6_to_pulses", LW'(to_p), LW'(1));
`else
    check("t6_to_never", LW'(to_p), '0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
